// File: rtl/ppu_pkg.sv
// Shared PPU types and address helpers for the background/window pixel path.
package ppu_pkg;

   typedef struct packed {
      logic ena;
      logic win_tile_map;
      logic win_ena;
      logic bg_win_tile_data;
      logic bg_tile_map;
      logic obj_size;
      logic obj_ena;
      logic bg_ena;
   } lcdc_t;

   typedef enum logic [1:0] {
      FETCH_TILE      = 2'd0,
      FETCH_DATA_LOW  = 2'd1,
      FETCH_DATA_HIGH = 2'd2,
      FETCH_PUSH      = 2'd3
   } fetcher_state_t;

   localparam logic [1:0]  TILE_MAP_PREFIX         = 2'b11;
   localparam logic [12:0] TILE_DATA_BASE_UNSIGNED = 13'h0000;
   localparam logic [12:0] TILE_DATA_BASE_SIGNED   = 13'h1000;

   function automatic logic [12:0] tile_map_addr(input logic map_sel, input logic [7:0] row,
                                                 input logic [4:0] col);
      return {TILE_MAP_PREFIX, map_sel, row[7:3], col};
   endfunction

   // Signed mode addresses tiles relative to 0x1000 with a two's-complement id.
   function automatic logic [12:0] tile_data_addr(input logic unsigned_mode, input logic [7:0] id,
                                                  input logic [2:0] row, input logic plane);
      logic [12:0] addr;
      if (unsigned_mode) begin
         addr = TILE_DATA_BASE_UNSIGNED | {1'b0, id, row, plane};
      end else begin
         addr = TILE_DATA_BASE_SIGNED + {id[7], id, 4'b0000} + {9'b0_0000_0000, row, plane};
      end
      return addr;
   endfunction

   function automatic logic [1:0] shade(input logic [7:0] pal, input logic [1:0] idx);
      logic [1:0] color;
      case (idx)
         2'd0:    color = pal[1:0];
         2'd1:    color = pal[3:2];
         2'd2:    color = pal[5:4];
         2'd3:    color = pal[7:6];
         default: color = 2'b00;
      endcase
      return color;
   endfunction

endpackage

// File: rtl/bg_pixel_fifo.sv
// Pixel FIFO of 2-bit colour indices: eight-pixel bulk push, single pop, flush.
module bg_pixel_fifo #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic                              push8,
   input  logic [7:0]                        push_lo,
   input  logic [7:0]                        push_hi,
   input  logic                              pop,
   output logic [1:0]                        pop_pix,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

   localparam int CW     = $clog2(FIFO_DEPTH + 1);
   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int GROUPS = FIFO_DEPTH / 8;
   localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam logic [CW-1:0] ROOM  = CW'(FIFO_DEPTH - 8);
   localparam logic [CW-1:0] EIGHT = CW'(8);
   localparam logic [CW-1:0] ONE   = CW'(1);

   logic [1:0]    mem_r [FIFO_DEPTH];
   logic [CW-1:0] count_r;
   logic [PW-1:0] rd_ptr_r;
   logic [GW-1:0] wr_grp_r;
   logic [PW-1:0] wr_base_s;
   logic          push_ok_s;
   logic          pop_ok_s;

   // Writes are always whole 8-pixel groups, so the write pointer counts groups.
   always_comb begin
      wr_base_s = PW'(wr_grp_r) << 3;
      push_ok_s = push8 && (count_r <= ROOM);
      pop_ok_s  = pop && (count_r != {CW{1'b0}});
   end

   // Storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r  <= {CW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         wr_grp_r <= {GW{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 2'b00;
      end else if (flush) begin
         count_r  <= {CW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         wr_grp_r <= {GW{1'b0}};
      end else begin
         if (push_ok_s) begin
            for (int i = 0; i < 8; i++) mem_r[wr_base_s + PW'(i)] <= {push_hi[7-i], push_lo[7-i]};
            wr_grp_r <= (wr_grp_r == GW'(GROUPS - 1)) ? {GW{1'b0}} : wr_grp_r + GW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= (rd_ptr_r == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
         end
         count_r <= count_r + (push_ok_s ? EIGHT : {CW{1'b0}}) - (pop_ok_s ? ONE : {CW{1'b0}});
      end
   end

   assign pop_pix = mem_r[rd_ptr_r];
   assign count   = count_r;

endmodule

// File: rtl/bg_pixel_pipe.sv
// Background/window pixel pipeline: tile fetcher feeding a pixel FIFO that is
// popped once per cycle into palette-shaded pixels for one scanline per start.
module bg_pixel_pipe
   import ppu_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int LINE_W     = 160
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  ly,
   input  logic [7:0]  scx,
   input  logic [7:0]  scy,
   input  logic [7:0]  wy,
   input  logic [7:0]  wx,
   input  logic [7:0]  bgp,
   input  lcdc_t       lcdc,
   output logic [12:0] vram_addr,
   input  logic [7:0]  vram_data,
   output logic        pix_valid,
   output logic [1:0]  pix_color,
   output logic        line_done
);

   localparam int XW = ($clog2(LINE_W + 1) > 8) ? $clog2(LINE_W + 1) : 8;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [XW-1:0] LAST_X = XW'(LINE_W - 1);
   localparam logic [CW-1:0] ROOM   = CW'(FIFO_DEPTH - 8);

   fetcher_state_t fetch_state_r, fetch_next_s;
   logic          active_r, done_pend_r, win_trig_r;
   logic [7:0]    win_line_r, tile_id_r, data_lo_r, data_hi_r;
   logic [4:0]    tile_col_r;
   logic [XW-1:0] vis_x_r;
   logic [2:0]    discard_r;
   logic          pix_valid_r, line_done_r;
   logic [1:0]    pix_color_r;

   logic [CW-1:0] fifo_count_s;
   logic [1:0]    fifo_pix_s, idx_s;
   logic [7:0]    row_s, wx_target_s;
   logic [12:0]   vram_addr_s;
   logic          map_sel_s, win_start_s, pop_s, emit_s, last_pix_s, flush_s, push_s;

   // Window trigger, FIFO handshake and pixel-emit decisions
   always_comb begin
      if (wx < 8'd7) begin
         wx_target_s = 8'd0;
      end else begin
         wx_target_s = wx - 8'd7;
      end
      win_start_s = active_r && lcdc.ena && !start && lcdc.win_ena && !win_trig_r &&
                    (ly >= wy) && (vis_x_r == XW'(wx_target_s));
      pop_s       = active_r && lcdc.ena && !start && !win_start_s && (fifo_count_s != {CW{1'b0}});
      emit_s      = pop_s && (discard_r == 3'd0);
      last_pix_s  = emit_s && (vis_x_r == LAST_X);
      flush_s     = !lcdc.ena || start || win_start_s || last_pix_s || !active_r;
      push_s      = active_r && (fetch_state_r == FETCH_PUSH) && (fifo_count_s <= ROOM) && !flush_s;
      row_s       = win_trig_r ? win_line_r : (ly + scy);
      map_sel_s   = win_trig_r ? lcdc.win_tile_map : lcdc.bg_tile_map;
      idx_s       = lcdc.bg_ena ? fifo_pix_s : 2'b00;
   end

   // Fetcher next state and VRAM address
   always_comb begin
      fetch_next_s = fetch_state_r;
      vram_addr_s  = 13'h0000;
      if (flush_s) begin
         fetch_next_s = FETCH_TILE;
      end else begin
         case (fetch_state_r)
            FETCH_TILE:      fetch_next_s = FETCH_DATA_LOW;
            FETCH_DATA_LOW:  fetch_next_s = FETCH_DATA_HIGH;
            FETCH_DATA_HIGH: fetch_next_s = FETCH_PUSH;
            FETCH_PUSH:      fetch_next_s = push_s ? FETCH_TILE : FETCH_PUSH;
            default:         fetch_next_s = FETCH_TILE;
         endcase
      end
      if (active_r && lcdc.ena) begin
         case (fetch_state_r)
            FETCH_TILE:      vram_addr_s = tile_map_addr(map_sel_s, row_s, tile_col_r);
            FETCH_DATA_LOW:  vram_addr_s = tile_data_addr(lcdc.bg_win_tile_data, tile_id_r, row_s[2:0], 1'b0);
            FETCH_DATA_HIGH: vram_addr_s = tile_data_addr(lcdc.bg_win_tile_data, tile_id_r, row_s[2:0], 1'b1);
            default:         vram_addr_s = 13'h0000;
         endcase
      end else begin
         vram_addr_s = 13'h0000;
      end
   end

   // Fetcher state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_state_r <= FETCH_TILE;
      end else begin
         fetch_state_r <= fetch_next_s;
      end
   end

   // VRAM bytes land at the end of each read state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tile_id_r <= 8'h00;
         data_lo_r <= 8'h00;
         data_hi_r <= 8'h00;
      end else if (active_r) begin
         case (fetch_state_r)
            FETCH_TILE:      tile_id_r <= vram_data;
            FETCH_DATA_LOW:  data_lo_r <= vram_data;
            FETCH_DATA_HIGH: data_hi_r <= vram_data;
            default: begin
            end
         endcase
      end
   end

   // Line sequencing, scroll discard, window counter and registered pixel outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_r    <= 1'b0;
         done_pend_r <= 1'b0;
         win_trig_r  <= 1'b0;
         win_line_r  <= 8'h00;
         tile_col_r  <= 5'd0;
         vis_x_r     <= {XW{1'b0}};
         discard_r   <= 3'd0;
         pix_valid_r <= 1'b0;
         pix_color_r <= 2'b00;
         line_done_r <= 1'b0;
      end else if (!lcdc.ena) begin
         // LCD off behaves like reset but keeps the window line counter
         active_r    <= 1'b0;
         done_pend_r <= 1'b0;
         win_trig_r  <= 1'b0;
         tile_col_r  <= 5'd0;
         vis_x_r     <= {XW{1'b0}};
         discard_r   <= 3'd0;
         pix_valid_r <= 1'b0;
         pix_color_r <= 2'b00;
         line_done_r <= 1'b0;
      end else if (start) begin
         active_r    <= 1'b1;
         done_pend_r <= 1'b0;
         win_trig_r  <= 1'b0;
         tile_col_r  <= scx[7:3];
         vis_x_r     <= {XW{1'b0}};
         discard_r   <= scx[2:0];
         pix_valid_r <= 1'b0;
         pix_color_r <= 2'b00;
         line_done_r <= 1'b0;
         if (ly == 8'd0) win_line_r <= 8'h00;
      end else begin
         line_done_r <= done_pend_r;
         done_pend_r <= last_pix_s;
         pix_valid_r <= emit_s;
         pix_color_r <= emit_s ? shade(bgp, idx_s) : 2'b00;
         if (last_pix_s) active_r <= 1'b0;
         if (win_start_s) win_trig_r <= 1'b1;
         else if (done_pend_r) win_trig_r <= 1'b0;
         if (done_pend_r && win_trig_r) win_line_r <= win_line_r + 8'd1;
         if (win_start_s) begin
            tile_col_r <= 5'd0;
            discard_r  <= 3'd0;
         end else begin
            if (push_s) tile_col_r <= tile_col_r + 5'd1;
            if (pop_s && (discard_r != 3'd0)) discard_r <= discard_r - 3'd1;
         end
         if (emit_s) vis_x_r <= vis_x_r + XW'(1);
      end
   end

   bg_pixel_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush_s),
      .push8   (push_s),
      .push_lo (data_lo_r),
      .push_hi (data_hi_r),
      .pop     (pop_s),
      .pop_pix (fifo_pix_s),
      .count   (fifo_count_s)
   );

   assign vram_addr = vram_addr_s;
   assign pix_valid = pix_valid_r;
   assign pix_color = pix_color_r;
   assign line_done = line_done_r;

endmodule

// File: tb/tb_bg_pixel_pipe.sv
// Directed bench for bg_pixel_pipe: a VRAM model and scanline reference model fill
// an expected-pixel queue at each start; DUT pixels are popped and compared.
module tb_bg_pixel_pipe;
   import ppu_pkg::*;

   localparam int LINE_W = 160;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  ly, scx, scy, wy, wx, bgp;
   lcdc_t       lcdc;
   logic [12:0] vram_addr;
   logic [7:0]  vram_data;
   logic        pix_valid;
   logic [1:0]  pix_color;
   logic        line_done;

   logic [7:0]  vram [8192];
   logic [1:0]  exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int          model_win_line = 0;
   bit          cur_win_on = 1'b0;

   always #5 clk = ~clk;

   assign vram_data = vram[vram_addr];

   bg_pixel_pipe #(.FIFO_DEPTH(16), .LINE_W(LINE_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ly(ly), .scx(scx), .scy(scy),
      .wy(wy), .wx(wx), .bgp(bgp), .lcdc(lcdc), .vram_addr(vram_addr),
      .vram_data(vram_data), .pix_valid(pix_valid), .pix_color(pix_color),
      .line_done(line_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] model_pix(input int x, input bit win_on, input int wxs, input int wline);
      int px, row, mapa, id, da, b, idx;
      logic sel;
      logic [7:0] lo, hi;
      if (win_on && x >= wxs) begin
         px = x - wxs; row = wline % 256; sel = lcdc.win_tile_map;
      end else begin
         px = (int'(scx) + x) % 256; row = (int'(ly) + int'(scy)) % 256; sel = lcdc.bg_tile_map;
      end
      mapa = 32'h1800 + (sel ? 32'h400 : 0) + (row / 8) * 32 + (px / 8) % 32;
      id = int'(vram[13'(mapa)]);
      if (lcdc.bg_win_tile_data) da = id * 16 + (row % 8) * 2;
      else da = 32'h1000 + ((id >= 128) ? id - 256 : id) * 16 + (row % 8) * 2;
      lo = vram[13'(da)];
      hi = vram[13'(da + 1)];
      b = 7 - (px % 8);
      idx = {30'd0, hi[b], lo[b]};
      if (!lcdc.bg_ena) idx = 0;
      return bgp[2*idx +: 2];
   endfunction

   // Called on a falling edge: queue the expected line, pulse start for one cycle.
   task automatic start_line(input int const_color);
      int wxs;
      wxs = (wx < 8'd7) ? 0 : int'(wx) - 7;
      if (ly == 8'd0) model_win_line = 0;
      cur_win_on = lcdc.win_ena && (ly >= wy) && (wxs < LINE_W);
      for (int x = 0; x < LINE_W; x++) begin
         if (const_color >= 0) exp_q.push_back(const_color[1:0]);
         else exp_q.push_back(model_pix(x, cur_win_on, wxs, model_win_line));
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("pix_valid_after_start", {31'd0, pix_valid}, 32'd0);
      check("line_done_after_start", {31'd0, line_done}, 32'd0);
   endtask

   // Compare pixels until line_done (stop_after=0) or until stop_after pixels seen.
   task automatic run_line(input int stop_after);
      int n = 0, cyc = 0, last = -10;
      bit done = 1'b0;
      logic [1:0] e;
      while (!done && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (pix_valid === 1'b1) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check($sformatf("pix_x%0d", n), {30'd0, pix_color}, {30'd0, e});
            end else begin
               check("unexpected_pixel", {31'd0, pix_valid}, 32'd0);
            end
            n++;
            last = cyc;
         end
         if (line_done === 1'b1) begin
            done = 1'b1;
            check("line_done_delay", cyc - last, 32'd1);
            check("pix_valid_at_done", {31'd0, pix_valid}, 32'd0);
            check("pixels_left_at_done", exp_q.size(), 32'd0);
         end else if (stop_after > 0 && n == stop_after) begin
            return;
         end
      end
      if (!done) begin
         check("line_done_timeout", {31'd0, line_done}, 32'd1);
      end else begin
         @(negedge clk);
         check("line_done_width", {31'd0, line_done}, 32'd0);
         if (cur_win_on) model_win_line++;
      end
   endtask

   task automatic fill(input int lo, input int hi, input logic [7:0] v);
      for (int a = lo; a <= hi; a++) vram[13'(a)] = v;
   endtask

   initial begin
      ly = 8'd0; scx = 8'd0; scy = 8'd0; wy = 8'd0; wx = 8'd0; bgp = 8'hE4;
      lcdc = '0;
      lcdc.ena = 1'b1; lcdc.bg_ena = 1'b1; lcdc.bg_win_tile_data = 1'b1;
      fill(0, 8191, 8'h00);
      repeat (3) @(negedge clk);
      check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
      check("rst_pix_color", {30'd0, pix_color}, 32'd0);
      check("rst_line_done", {31'd0, line_done}, 32'd0);
      check("rst_vram_addr", {19'd0, vram_addr}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_pix_valid", {31'd0, pix_valid}, 32'd0);
      check("idle_vram_addr", {19'd0, vram_addr}, 32'd0);

      // Uniform tile 1, row 0 = lo FF hi 00: every pixel is index 1 -> colour 1
      fill(32'h1800, 32'h1BFF, 8'h01);
      vram[13'h0010] = 8'hFF; vram[13'h0011] = 8'h00;
      start_line(1);
      run_line(0);

      // Random VRAM, fine scroll 5
      for (int a = 0; a < 8192; a++) vram[a] = 8'($urandom);
      scx = 8'd5; scy = 8'd3; ly = 8'd10;
      start_line(-1);
      run_line(0);

      // Column wrap, vertical wrap, signed tile data, different palette
      lcdc.bg_win_tile_data = 1'b0; scx = 8'd200; scy = 8'd250; ly = 8'd77; bgp = 8'h1B;
      start_line(-1);
      run_line(0);

      // Background disabled: every pixel shades index 0
      lcdc.bg_ena = 1'b0; ly = 8'd20;
      start_line(-1);
      run_line(0);
      lcdc.bg_ena = 1'b1;

      // Signed tile data with id 0x80 reads row 0 at 0x0800/0x0801
      fill(0, 8191, 8'h00);
      fill(32'h1800, 32'h1BFF, 8'h80);
      vram[13'h0800] = 8'hA5; vram[13'h0801] = 8'h3C;
      ly = 8'd0; scx = 8'd0; scy = 8'd0; bgp = 8'hE4;
      start_line(-1);
      check("map_addr", {19'd0, vram_addr}, 32'h1800);
      @(negedge clk);
      check("data_lo_addr", {19'd0, vram_addr}, 32'h0800);
      @(negedge clk);
      check("data_hi_addr", {19'd0, vram_addr}, 32'h0801);
      run_line(0);

      // Window at wx=87 (x=80) over two lines; map 1 holds tile 2
      lcdc.bg_win_tile_data = 1'b1;
      fill(0, 8191, 8'h00);
      fill(32'h1800, 32'h1BFF, 8'h01);
      fill(32'h1C00, 32'h1FFF, 8'h02);
      vram[13'h0010] = 8'hFF; vram[13'h0011] = 8'h00;
      vram[13'h0020] = 8'h00; vram[13'h0021] = 8'hFF;
      vram[13'h0022] = 8'hFF; vram[13'h0023] = 8'hFF;
      lcdc.win_ena = 1'b1; lcdc.win_tile_map = 1'b1; wy = 8'd0; wx = 8'd87; ly = 8'd0;
      start_line(-1);
      run_line(0);
      ly = 8'd1;
      start_line(-1);
      run_line(0);
      lcdc.win_ena = 1'b0;

      // Restart mid-line at x=40: the abandoned line must not complete
      for (int a = 0; a < 8192; a++) vram[a] = 8'($urandom);
      ly = 8'd5; scx = 8'd13; scy = 8'd0;
      start_line(-1);
      run_line(40);
      exp_q.delete();
      start_line(-1);
      run_line(0);

      // LCD disabled mid-line: outputs drop, no pixels until the next start
      start_line(-1);
      run_line(30);
      lcdc.ena = 1'b0;
      @(negedge clk);
      check("lcd_off_pix_valid", {31'd0, pix_valid}, 32'd0);
      check("lcd_off_vram_addr", {19'd0, vram_addr}, 32'd0);
      lcdc.ena = 1'b1;
      exp_q.delete();
      repeat (5) begin
         @(negedge clk);
         check("lcd_on_idle_pix", {31'd0, pix_valid}, 32'd0);
      end

      // Asynchronous reset at x=100
      start_line(-1);
      run_line(100);
      rst_n = 1'b0;
      #1;
      check("async_rst_pix_valid", {31'd0, pix_valid}, 32'd0);
      check("async_rst_pix_color", {30'd0, pix_color}, 32'd0);
      check("async_rst_line_done", {31'd0, line_done}, 32'd0);
      check("async_rst_vram_addr", {19'd0, vram_addr}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      model_win_line = 0;
      repeat (10) begin
         @(negedge clk);
         check("post_rst_idle_pix", {31'd0, pix_valid}, 32'd0);
         check("post_rst_idle_done", {31'd0, line_done}, 32'd0);
      end
      start_line(-1);
      run_line(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bg_pixel_pipe.md
BG_PIXEL_PIPE -- requirements
Module: bg_pixel_pipe

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, pixel FIFO capacity (multiple of 8, >= 16).
REQ-002 SHALL have parameter LINE_W, default 160, visible pixels per line.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse beginning a line's draw phase.
REQ-006 SHALL have ports ly, scx, scy, wy, wx, bgp  input  8 each  PPU registers, sampled live.
REQ-007 SHALL have port lcdc  input  lcdc_t  LCD control fields.
REQ-008 SHALL have port vram_addr  output  13  VRAM byte address; vram_data input 8, valid in the same cycle.
REQ-009 SHALL have port pix_valid  output  1  pix_color (output 2) is a visible shaded pixel.
REQ-010 SHALL have port line_done  output  1  one-cycle pulse after the last visible pixel.

Function
REQ-011 Fetcher SHALL step FETCH_TILE -> FETCH_DATA_LOW -> FETCH_DATA_HIGH -> FETCH_PUSH, one cycle per read state, capturing vram_data at the end of that cycle.
REQ-012 FETCH_PUSH SHALL load 8 pixels (MSB first) when FIFO free slots >= 8, advance tile column by 1 mod 32, return to FETCH_TILE; otherwise hold.
REQ-013 Tile-map address SHALL be {2'b11, map_sel, row[7:3], col[4:0]}; map_sel = lcdc.bg_tile_map for background, lcdc.win_tile_map for window.
REQ-014 BG row SHALL be (ly + scy) mod 256; first column SHALL be scx[7:3]; wrap at 32 columns.
REQ-015 Tile data address SHALL be {1'b0, id, row[2:0], plane} when lcdc.bg_win_tile_data=1, else 13'h1000 + signed(id)*16 + row[2:0]*2 + plane.
REQ-016 FIFO SHALL pop one pixel per cycle while drawing and count > 0; push and pop SHALL be allowed in the same cycle.
REQ-017 First scx[2:0] popped pixels of a line SHALL be discarded with pix_valid=0.
REQ-018 pix_color SHALL be bgp[2*idx+1 -: 2] for 2-bit index idx; when lcdc.bg_ena=0, idx SHALL be forced to 0.
REQ-019 Window SHALL trigger once per line when lcdc.win_ena=1, ly >= wy, and the next visible x equals wx-7 (wx < 7 triggers at x=0): FIFO flushed, fetcher restarted at window column 0, row = window line counter.
REQ-020 Window line counter SHALL clear on start with ly=0, and increment on line_done of each line where the window triggered.
REQ-021 After LINE_W visible pixels, SHALL assert line_done one cycle, clear pix_valid, and idle (vram_addr held 0) until start.
REQ-022 start during an active line SHALL abandon it: FIFO emptied, fetcher to FETCH_TILE, visible-x 0, no line_done.
REQ-023 lcdc.ena=0 SHALL force idle state equivalent to reset, without touching the window counter.

Reset
REQ-024 rst_n low SHALL asynchronously clear: fetcher FETCH_TILE, FIFO count 0, visible-x 0, discard count 0, window counter 0, idle.
REQ-025 Outputs during reset SHALL be pix_valid=0, pix_color=0, line_done=0, vram_addr=0.
REQ-026 Reset deasserted mid-frame SHALL produce no pixel until the next start.

Structure
REQ-027 lcdc_t, fetcher_state_t, and tile-map/tile-data base constants SHALL live in a shared ppu_pkg package.
REQ-028 FIFO SHALL be sub-module bg_pixel_fifo (parametrised by FIFO_DEPTH; push8, pop, flush, count).

Verification
REQ-029 scx=0, scy=0, map id 0x01 everywhere, tile 1 row 0 = lo 0xFF hi 0x00, bgp=0xE4 -> 160 pixels of color 1, line_done 1 cycle after the 160th.
REQ-030 scx=5 -> first 5 popped pixels suppressed, first visible pixel is pixel 5 of tile column 0.
REQ-031 lcdc.bg_win_tile_data=0, id 0x80, row 0 -> data reads at 13'h0800 and 13'h0801.
REQ-032 win_ena=1, wy=0, wx=87 -> pixels 0-79 from BG map, pixel 80 onward from window column 0; next line window row 1.
REQ-033 start pulsed at visible-x 40 -> no line_done, new line begins at x 0 with correct pixels.
REQ-034 rst_n low at visible-x 100 -> outputs zero immediately; after release, idle until start.
